// File: rtl/axis_to_rs232_pkg.sv
// Shared definitions for the RS232 transmit path: FSM state encoding,
// frame constants and the baud divider sizing helpers.
package axis_to_rs232_pkg;

    // Line-state encoding shared by the transmit FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int         DATA_BITS      = 8;
    // Synchroniser reset value: both stages read "remote not ready".
    localparam logic [1:0] CTS_SYNC_RESET = 2'b11;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_baud_count(input real clock_freq, input real baud_rate);
        return $rtoi((clock_freq / baud_rate) + 0.5);
    endfunction

    // Width of the baud down-counter; never less than one bit.
    function automatic int calc_baud_width(input int count);
        return (count < 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/axis_to_rs232_if.sv
// AXI-stream byte channel feeding the RS232 transmitter.
interface axis_to_rs232_if;
    logic [7:0] idata;
    logic       ivalid;
    logic       iready;

    modport master (output idata, output ivalid, input  iready);
    modport slave  (input  idata, input  ivalid, output iready);
endinterface

// File: rtl/axis_to_rs232_baud_divider.sv
// Bit-time down-counter. restart reloads the counter synchronously; tick
// pulses for one clock when the counter underflows, then it reloads, so
// ticks are exactly COUNT clocks apart.
module axis_to_rs232_baud_divider
    import axis_to_rs232_pkg::*;
#(
    parameter int COUNT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic restart,
    output logic tick
);

    localparam int               WIDTH  = calc_baud_width(COUNT);
    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(COUNT - 1);
    localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    if (COUNT < 2) begin : g_bad_count
        $error("axis_to_rs232_baud_divider: COUNT must be at least 2");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tick = (cnt_q == ZERO) && !restart;

    // Next count: reload on restart or underflow, otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = RELOAD;
        end else if (cnt_q == ZERO) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_to_rs232.sv
// RS232 transmitter: one-byte holding register in front of an 8N1/8N2
// serialiser, gated by CTSn flow control sampled only at frame start.
module axis_to_rs232
    import axis_to_rs232_pkg::*;
#(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  STOP_BITS  = 1
) (
    input  logic             clock,
    input  logic             resetn,
    axis_to_rs232_if.slave   s_axis,
    output logic             txd_pin,
    input  logic             ctsn_pin,
    output logic             busy
);

    localparam int         BAUD_COUNT    = calc_baud_count(CLOCK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("axis_to_rs232: STOP_BITS must be 1 or 2");
    end
    if (BAUD_COUNT < 2) begin : g_bad_baud
        $error("axis_to_rs232: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end

    tx_state_e  state_q,     state_d;
    logic [7:0] hold_q,      hold_d;
    logic       hold_full_q, hold_full_d;
    logic       iready_q,    iready_d;
    logic [7:0] shift_q,     shift_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic       txd_q,       txd_d;
    logic       busy_q,      busy_d;
    logic [1:0] cts_sync_q,  cts_sync_d;

    logic accept_s;
    logic load_s;
    logic cts_ok_s;
    logic baud_restart_s;
    logic baud_tick_s;

    assign accept_s       = s_axis.ivalid && iready_q;
    assign cts_ok_s       = !cts_sync_q[1];
    // The divider sits at a full bit time while idle so a start bit always
    // lasts exactly one bit period from the edge it begins on.
    assign baud_restart_s = (state_q == ST_IDLE);

    axis_to_rs232_baud_divider #(
        .COUNT (BAUD_COUNT)
    ) u_baud (
        .clock   (clock),
        .resetn  (resetn),
        .restart (baud_restart_s),
        .tick    (baud_tick_s)
    );

    // Two-stage synchroniser for the asynchronous CTSn pin.
    always_comb begin
        cts_sync_d = {cts_sync_q[0], ctsn_pin};
    end

    // Frame sequencing, shift register and bit counter; load_s marks the
    // edge where the held byte moves into the shifter.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        load_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full_q && cts_ok_s) begin
                    state_d = ST_START;
                    shift_d = hold_q;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick_s) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick_s) begin
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d   = ST_STOP;
                        bit_cnt_d = 3'd0;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_tick_s) begin
                    if (bit_cnt_q == LAST_STOP_BIT) begin
                        // Chain straight into the next frame when possible.
                        if (hold_full_q && cts_ok_s) begin
                            state_d = ST_START;
                            shift_d = hold_q;
                            load_s  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 3'd0;
            end
        endcase
    end

    // Holding register: emptied by a load, filled by an accepted beat.
    // Both cannot coincide because iready is low while the register is full.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load_s) begin
            hold_full_d = 1'b0;
        end else if (accept_s) begin
            hold_full_d = 1'b1;
            hold_d      = s_axis.idata;
        end else begin
            hold_full_d = hold_full_q;
        end
        iready_d = !hold_full_d;
        busy_d   = hold_full_d || (state_d != ST_IDLE);
    end

    // Line level for the coming cycle, registered so txd_pin is glitch-free.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_IDLE:  txd_d = 1'b1;
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            ST_STOP:  txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            iready_q    <= 1'b0;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            cts_sync_q  <= CTS_SYNC_RESET;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            iready_q    <= iready_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            cts_sync_q  <= cts_sync_d;
        end
    end

    assign s_axis.iready = iready_q;
    assign txd_pin       = txd_q;
    assign busy          = busy_q;

endmodule
